// File: rtl/vending_machine_param.sv
// Parametrised vending controller: accumulates coin credit, vends one product,
// waits for the dispenser acknowledge, then pays change or a refund one unit per cycle.
module vending_machine_param #(
  parameter int CREDIT_W    = 8,
  parameter int PRICE       = 25,
  parameter int CHANGE_UNIT = 5,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                coin_valid_i,
  input  logic [CREDIT_W-1:0] coin_value_i,
  input  logic                cancel_i,
  input  logic                vend_ack_i,
  output logic                coin_accept_o,
  output logic                coin_reject_o,
  output logic                vend_o,
  output logic                change_valid_o,
  output logic                fault_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    VEND     = 2'd2,
    DISPENSE = 2'd3
  } state_e;

  localparam int                TmoW     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CREDIT_W:0] PriceExt = (CREDIT_W + 1)'(PRICE);
  localparam logic [CREDIT_W-1:0] PriceW = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UnitW  = CREDIT_W'(CHANGE_UNIT);
  localparam logic [TmoW-1:0]   TmoLast  = TmoW'(ACK_TIMEOUT - 1);

  state_e              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [TmoW-1:0]     tmo_q;
  logic                vend_q;
  logic                coin_accept_q;
  logic                coin_reject_q;
  logic                change_valid_q;
  logic                fault_q;

  logic [CREDIT_W:0]   sum_d;
  logic [CREDIT_W-1:0] vendCredit_d;
  logic                coinOk;

  // The extra sum bit flags overflow; a coin that would wrap the credit is refused.
  assign sum_d        = {1'b0, credit_q} + {1'b0, coin_value_i};
  assign vendCredit_d = sum_d[CREDIT_W-1:0] - PriceW;
  assign coinOk       = (coin_value_i != '0) &&
                        ((coin_value_i % UnitW) == '0) &&
                        !sum_d[CREDIT_W];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      tmo_q          <= '0;
      vend_q         <= 1'b0;
      coin_accept_q  <= 1'b1;
      coin_reject_q  <= 1'b0;
      change_valid_q <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      coin_reject_q  <= 1'b0;
      change_valid_q <= 1'b0;
      fault_q        <= 1'b0;
      case (state_q)
        IDLE, COLLECT: begin
          // Cancel only matters once credit is held; a coin offered alongside it is refused.
          if (state_q == COLLECT && cancel_i) begin
            state_q       <= DISPENSE;
            coin_accept_q <= 1'b0;
            coin_reject_q <= coin_valid_i;
          end else if (coin_valid_i) begin
            if (!coinOk) begin
              coin_reject_q <= 1'b1;
            end else if (sum_d >= PriceExt) begin
              state_q       <= VEND;
              credit_q      <= vendCredit_d;
              vend_q        <= 1'b1;
              tmo_q         <= '0;
              coin_accept_q <= 1'b0;
            end else begin
              state_q  <= COLLECT;
              credit_q <= sum_d[CREDIT_W-1:0];
            end
          end
        end
        VEND: begin
          coin_reject_q <= coin_valid_i;
          if (vend_ack_i) begin
            vend_q <= 1'b0;
            if (credit_q == '0) begin
              state_q       <= IDLE;
              coin_accept_q <= 1'b1;
            end else begin
              state_q <= DISPENSE;
            end
          end else if (tmo_q == TmoLast) begin
            // The refund fits: credit here is what remained after PRICE was taken.
            vend_q   <= 1'b0;
            fault_q  <= 1'b1;
            credit_q <= credit_q + PriceW;
            state_q  <= DISPENSE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        DISPENSE: begin
          coin_reject_q <= coin_valid_i;
          if (credit_q != '0) begin
            change_valid_q <= 1'b1;
            credit_q       <= credit_q - UnitW;
          end else begin
            state_q       <= IDLE;
            coin_accept_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= IDLE;
          coin_accept_q <= 1'b1;
        end
      endcase
    end
  end

  assign coin_accept_o  = coin_accept_q;
  assign coin_reject_o  = coin_reject_q;
  assign vend_o         = vend_q;
  assign change_valid_o = change_valid_q;
  assign fault_o        = fault_q;
  assign credit_o       = credit_q;
  assign state_o        = state_q;

endmodule
